// File: rtl/arm_dp_decode_stage.sv
// arm_dp_decode_stage: registered ARM data-processing decode (operands, barrel shifter, condition check).
// Define ROR_RRX_EN to decode immediate ROR/RRX and register ROR instead of marking them undefined.
module arm_dp_decode_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 4,
    parameter int OUT_STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [3:0]        flags_nzcv,
    output logic [REG_AW-1:0] rd_addr0,
    output logic [REG_AW-1:0] rd_addr1,
    output logic [REG_AW-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_operand0,
    output logic [DATA_W-1:0] out_operand1,
    output logic              out_shift_carry,
    output logic [3:0]        out_opcode,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_update_flags,
    output logic              out_nop,
    output logic              out_undef,
    output logic              stall_if
);

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("arm_dp_decode_stage: DATA_W must be 32");
        end
        if (OUT_STAGES != 1 && OUT_STAGES != 2) begin : g_bad_stages
            $error("arm_dp_decode_stage: OUT_STAGES must be 1 or 2");
        end
    endgenerate

    typedef struct packed {
        logic [DATA_W-1:0] op0;
        logic [DATA_W-1:0] op1;
        logic              carry;
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic              update_flags;
        logic              nop;
        logic              undef;
    } bundle_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
        return 32'({x, x} >> r);
    endfunction

    logic        n, z, c, v;
    logic [3:0]  cond;
    logic [1:0]  sh_type;
    logic        imm_form, reg_shift;
    logic        base_pass, cond_pass, ror_undef, undef;
    logic [7:0]  amt;
    logic [32:0] lsl_w, lsr_w;
    logic signed [32:0] asr_w;
    logic [31:0] rm, imm_rot, ror_res, sh_res;
    logic        sh_c;
    logic        unused_rs_hi;
    bundle_t     dec;

    assign {n, z, c, v} = flags_nzcv;
    assign cond         = instruction[31:28];
    assign imm_form     = instruction[25];
    assign reg_shift    = instruction[4];
    assign sh_type      = instruction[6:5];
    assign rm           = rd_data1;
    assign unused_rs_hi = ^rd_data2[DATA_W-1:8];

    assign rd_addr0 = REG_AW'(instruction[19:16]);
    assign rd_addr1 = REG_AW'(instruction[3:0]);
    assign rd_addr2 = REG_AW'(instruction[11:8]);

    // Immediate LSR #0 and ASR #0 encode a shift of 32
    assign amt = reg_shift ? rd_data2[7:0] :
                 (instruction[11:7] == 5'd0 && (sh_type[0] ^ sh_type[1])) ? 8'd32 :
                 {3'b0, instruction[11:7]};

    assign lsl_w   = {1'b0, rm} << amt;
    assign lsr_w   = {rm, 1'b0} >> amt;
    assign asr_w   = $signed({rm, 1'b0}) >>> (amt > 8'd32 ? 8'd32 : amt);
    assign ror_res = ror32(rm, amt[4:0]);
    assign imm_rot = ror32({24'b0, instruction[7:0]}, {instruction[11:8], 1'b0});

    always_comb begin
        sh_res = rm;
        sh_c   = c;
        if (amt == 8'd0) begin
            if (sh_type == 2'b11 && !reg_shift) {sh_res, sh_c} = {c, rm[31:1], rm[0]};
        end else begin
            case (sh_type)
                2'b00:   {sh_c, sh_res} = lsl_w;
                2'b01:   {sh_res, sh_c} = lsr_w;
                2'b10:   {sh_res, sh_c} = asr_w;
                default: {sh_res, sh_c} = {ror_res, ror_res[31]};
            endcase
        end
    end

    assign base_pass = cond[3:1] == 3'd0 ? z :
                       cond[3:1] == 3'd1 ? c :
                       cond[3:1] == 3'd2 ? n :
                       cond[3:1] == 3'd3 ? v :
                       cond[3:1] == 3'd4 ? c & ~z :
                       cond[3:1] == 3'd5 ? n == v :
                       cond[3:1] == 3'd6 ? ~z & (n == v) : 1'b1;
    // Odd codes invert their even partner; 1111 never executes
    assign cond_pass = cond == 4'b1111 ? 1'b0 : base_pass ^ (cond[0] & (cond[3:1] != 3'd7));

`ifdef ROR_RRX_EN
    assign ror_undef = 1'b0;
`else
    assign ror_undef = ~imm_form & (sh_type == 2'b11);
`endif

    assign undef = (instruction[27:26] != 2'b00)
                 | (~imm_form & instruction[7] & reg_shift)
                 | ((instruction[24:23] == 2'b10) & ~instruction[20])
                 | ror_undef;

    always_comb begin
        dec.op0          = rd_data0;
        dec.op1          = undef ? '0 : imm_form ? imm_rot : sh_res;
        dec.carry        = undef ? 1'b0 : imm_form ? (instruction[11:8] != 4'd0 ? imm_rot[31] : c) : sh_c;
        dec.opcode       = instruction[24:21];
        dec.rd           = REG_AW'(instruction[15:12]);
        dec.nop          = undef | ~cond_pass;
        dec.undef        = undef;
        dec.update_flags = instruction[20] & ~dec.nop;
    end

    bundle_t                s     [OUT_STAGES];
    bundle_t                src   [OUT_STAGES];
    logic [OUT_STAGES-1:0] sv, src_v, rdy, ld;

    generate
        if (OUT_STAGES == 2) begin : g_two
            assign rdy = {out_ready, ~sv[1] | out_ready};
        end else begin : g_one
            assign rdy = out_ready;
        end
    endgenerate

    assign ld       = ~sv | rdy;
    assign in_ready = ld[0];
    assign stall_if = in_valid & ~in_ready;

    always_comb begin
        src_v  = OUT_STAGES'({sv, in_valid});
        src[0] = dec;
        for (int k = 1; k < OUT_STAGES; k++) src[k] = s[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
            for (int k = 0; k < OUT_STAGES; k++) s[k] <= '0;
        end else begin
            for (int k = 0; k < OUT_STAGES; k++) begin
                if (ld[k]) begin
                    sv[k] <= src_v[k];
                    s[k]  <= src[k];
                end
            end
        end
    end

    assign out_valid        = sv[OUT_STAGES-1];
    assign out_operand0     = s[OUT_STAGES-1].op0;
    assign out_operand1     = s[OUT_STAGES-1].op1;
    assign out_shift_carry  = s[OUT_STAGES-1].carry;
    assign out_opcode       = s[OUT_STAGES-1].opcode;
    assign out_rd           = s[OUT_STAGES-1].rd;
    assign out_update_flags = s[OUT_STAGES-1].update_flags;
    assign out_nop          = s[OUT_STAGES-1].nop;
    assign out_undef        = s[OUT_STAGES-1].undef;

endmodule

// File: tb/tb_arm_dp_decode_stage.sv
// tb_arm_dp_decode_stage: directed and randomized checks of arm_dp_decode_stage against a bit-serial reference model.
module tb_arm_dp_decode_stage;
    localparam int OUT_STAGES = 1;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, stall_if;
    logic [31:0] instruction, rd_data0, rd_data1, rd_data2, out_operand0, out_operand1;
    logic [3:0]  flags_nzcv, rd_addr0, rd_addr1, rd_addr2, out_opcode, out_rd;
    logic        out_shift_carry, out_update_flags, out_nop, out_undef;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    arm_dp_decode_stage #(.DATA_W(32), .REG_AW(4), .OUT_STAGES(OUT_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flags_nzcv(flags_nzcv),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operand0(out_operand0), .out_operand1(out_operand1), .out_shift_carry(out_shift_carry),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_update_flags(out_update_flags),
        .out_nop(out_nop), .out_undef(out_undef), .stall_if(stall_if)
    );

    typedef struct {
        logic [31:0] op0, op1;
        logic        carry;
        logic [3:0]  opcode, rd;
        logic        uf, nop, und, chk_op1, chk_carry;
    } exp_t;

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic nn, zz, cf, vv;
        {nn, zz, cf, vv} = f;
        case (cc)
            4'h0: return zz;
            4'h1: return !zz;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return nn;
            4'h5: return !nn;
            4'h6: return vv;
            4'h7: return !vv;
            4'h8: return cf && !zz;
            4'h9: return !cf || zz;
            4'hA: return nn == vv;
            4'hB: return nn != vv;
            4'hC: return !zz && nn == vv;
            4'hD: return zz || nn != vv;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Shifts are performed one bit at a time so the carry is literally the last bit moved out
    function automatic exp_t model(input logic [31:0] ins, rn, rm, rs, input logic [3:0] f);
        exp_t e;
        logic [31:0] x;
        logic cy, base_und;
        int amount;
        base_und = ins[27:26] != 2'b00 || (!ins[25] && ins[7] && ins[4]) ||
                   (ins[24:21] >= 4'd8 && ins[24:21] <= 4'd11 && !ins[20]);
        e.und = base_und;
`ifndef ROR_RRX_EN
        if (!ins[25] && ins[6:5] == 2'd3) e.und = 1'b1;
`endif
        e.op0 = rn;
        e.opcode = ins[24:21];
        e.rd = ins[15:12];
        e.nop = e.und || !cond_ok(ins[31:28], f);
        e.uf = ins[20] && !e.nop;
        x = rm;
        cy = f[1];
        if (ins[25]) begin
            x = {24'b0, ins[7:0]};
            for (int i = 0; i < 2 * int'(ins[11:8]); i++) x = {x[0], x[31:1]};
            cy = ins[11:8] != 4'd0 ? x[31] : f[1];
        end else begin
            amount = ins[4] ? int'(rs[7:0]) : int'(ins[11:7]);
            if (!ins[4] && amount == 0 && (ins[6:5] == 2'd1 || ins[6:5] == 2'd2)) amount = 32;
            if (!ins[4] && amount == 0 && ins[6:5] == 2'd3) begin
                x = {f[1], rm[31:1]};
                cy = rm[0];
            end else begin
                for (int i = 0; i < amount; i++) begin
                    case (ins[6:5])
                        2'd0: begin cy = x[31]; x = x << 1; end
                        2'd1: begin cy = x[0]; x = x >> 1; end
                        2'd2: begin cy = x[0]; x = {x[31], x[31:1]}; end
                        default: begin x = {x[0], x[31:1]}; cy = x[31]; end
                    endcase
                end
            end
        end
        e.op1 = e.und ? 32'd0 : x;
        e.carry = cy;
        e.chk_op1 = !base_und;
        e.chk_carry = !e.und;
        return e;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r = $urandom;
        if ($urandom_range(7) != 0) r[27:26] = 2'b00;
        if ($urandom_range(2) == 0) r[31:28] = 4'hE;
        return r;
    endfunction

    function automatic logic [31:0] rand_rs();
        int sel = $urandom_range(3);
        logic [7:0] a = sel == 0 ? 8'd0 : sel == 1 ? 8'($urandom_range(34, 30)) :
                        sel == 2 ? 8'($urandom_range(31, 1)) : 8'($urandom);
        return ($urandom & 32'hFFFF_FF00) | {24'b0, a};
    endfunction

    task automatic drive(input logic [31:0] ins, rn, rm, rs, input logic [3:0] f);
        instruction = ins;
        rd_data0 = rn;
        rd_data1 = rm;
        rd_data2 = rs;
        flags_nzcv = f;
    endtask

    task automatic drive_rand();
        drive(rand_ins(), $urandom, $urandom, rand_rs(), 4'($urandom));
    endtask

    task automatic run_one(input logic [31:0] ins, rn, rm, rs, input logic [3:0] f, output exp_t got, output int lat);
        @(negedge clk);
        drive(ins, rn, rm, rs, f);
        in_valid = 1'b1;
        out_ready = 1'b1;
        lat = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drive_rand();
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                got = '{out_operand0, out_operand1, out_shift_carry, out_opcode, out_rd,
                        out_update_flags, out_nop, out_undef, 1'b1, 1'b1};
            end
        end
    endtask

    task automatic test_reset();
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if ({out_operand0, out_operand1, out_shift_carry, out_opcode, out_rd, out_update_flags, out_nop, out_undef} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h/%h nonzero exp=0", out_operand0, out_operand1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_rd_addr();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_rand();
            #1;
            total++;
            if ({rd_addr0, rd_addr1, rd_addr2} !== {instruction[19:16], instruction[3:0], instruction[11:8]}) begin
                bad++; $display("FAIL rd_addr ins=%h got=%h/%h/%h", instruction, rd_addr0, rd_addr1, rd_addr2);
            end
        end
    endtask

    task automatic test_rotate_imm();
        exp_t g; int lat;
        run_one(32'hE3A004FF, $urandom, $urandom, $urandom, 4'b0000, g, lat);
        total++; if (lat != OUT_STAGES) begin bad++; $display("FAIL rot_latency got=%0d exp=%0d", lat, OUT_STAGES); end
        total++; if (g.op1 !== 32'hFF00_0000) begin bad++; $display("FAIL rot_op1 got=%h exp=ff000000", g.op1); end
        total++; if (g.carry !== 1'b1) begin bad++; $display("FAIL rot_carry got=%b exp=1", g.carry); end
        total++; if ({g.nop, g.und, g.opcode, g.rd} !== {2'b00, 4'hD, 4'h0}) begin
            bad++; $display("FAIL rot_fields got=%b%b %h %h exp=00 d 0", g.nop, g.und, g.opcode, g.rd);
        end
    endtask

    task automatic test_lsr32();
        exp_t g; int lat;
        run_one(32'hE1A00021, $urandom, 32'h8000_0001, $urandom, 4'b0000, g, lat);
        total++; if ({g.op1, g.carry} !== {32'd0, 1'b1}) begin bad++; $display("FAIL lsr32 got=%h/%b exp=0/1", g.op1, g.carry); end
    endtask

    task automatic test_reg_asr();
        exp_t g; int lat;
        run_one(32'hE1A00251, $urandom, 32'h8000_0000, 32'd40, 4'b0000, g, lat);
        total++; if ({g.op1, g.carry} !== {32'hFFFF_FFFF, 1'b1}) begin bad++; $display("FAIL reg_asr got=%h/%b exp=ffffffff/1", g.op1, g.carry); end
    endtask

    task automatic test_cond();
        exp_t g; int lat;
        run_one(32'h03A00001, $urandom, $urandom, $urandom, 4'b0000, g, lat);
        total++; if ({lat == OUT_STAGES, g.nop, g.uf} !== 3'b110) begin bad++; $display("FAIL eq_fail got=lat%0d nop%b uf%b exp=nop1 uf0", lat, g.nop, g.uf); end
        run_one(32'h03A00001, $urandom, $urandom, $urandom, 4'b0100, g, lat);
        total++; if ({g.nop, g.op1} !== {1'b0, 32'd1}) begin bad++; $display("FAIL eq_pass got=nop%b op1=%h exp=nop0 op1=1", g.nop, g.op1); end
        run_one(32'h03B00001, $urandom, $urandom, $urandom, 4'b0100, g, lat);
        total++; if (g.uf !== 1'b1) begin bad++; $display("FAIL movs_uf got=%b exp=1", g.uf); end
        run_one(32'h03B00001, $urandom, $urandom, $urandom, 4'b0000, g, lat);
        total++; if (g.uf !== 1'b0) begin bad++; $display("FAIL movs_fail_uf got=%b exp=0", g.uf); end
    endtask

    task automatic test_rrx();
        exp_t g; int lat;
        run_one(32'hE1A00060, $urandom, 32'd2, $urandom, 4'b0010, g, lat);
`ifdef ROR_RRX_EN
        total++; if ({g.op1, g.carry, g.nop} !== {32'h8000_0001, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rrx got=%h/%b nop%b exp=80000001/0 nop0", g.op1, g.carry, g.nop);
        end
`else
        total++; if ({g.op1, g.und, g.nop} !== {32'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL rrx_undef got=%h und%b nop%b exp=0 und1 nop1", g.op1, g.und, g.nop);
        end
`endif
    endtask

    task automatic test_edges();
        logic [31:0] t_ins [12] = '{32'hE1A00001, 32'hE1A00211, 32'hE1A00211, 32'hE1A00211, 32'hE1A00231, 32'hE1A00231,
                                    32'hE1A00271, 32'hE1A00861, 32'hE0000091, 32'hE1000001, 32'hF3A00001, 32'hE3A000FF};
        logic [31:0] t_rs  [12] = '{32'd0, 32'd32, 32'd33, 32'h100, 32'd32, 32'd40,
                                    32'd32, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        exp_t g, e; int lat;
        logic [31:0] rn, rm;
        for (int i = 0; i < 12; i++) begin
            rn = $urandom;
            rm = $urandom | 32'h8000_0001;
            e = model(t_ins[i], rn, rm, t_rs[i], 4'b0010);
            run_one(t_ins[i], rn, rm, t_rs[i], 4'b0010, g, lat);
            total++;
            if (lat != OUT_STAGES || g.op0 !== e.op0 || (e.chk_op1 && g.op1 !== e.op1) || (e.chk_carry && g.carry !== e.carry) ||
                {g.opcode, g.rd, g.uf, g.nop, g.und} !== {e.opcode, e.rd, e.uf, e.nop, e.und}) begin
                bad++;
                $display("FAIL edge%0d ins=%h got=%h/%b u%b n%b f%b exp=%h/%b u%b n%b f%b lat=%0d", i, t_ins[i],
                         g.op1, g.carry, g.und, g.nop, g.uf, e.op1, e.carry, e.und, e.nop, e.uf, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t q[$]; exp_t e;
        logic [31:0] l_ins [4], l_rn [4], l_rm [4], l_rs [4];
        logic [3:0] l_f [4];
        logic [31:0] h_op0, h_op1;
        logic hold = 1'b0, stalled = 1'b0;
        int sent = 0, recv = 0, cyc = 0;
        for (int k = 0; k < 4; k++) begin
            l_ins[k] = rand_ins(); l_rn[k] = 32'd100 + k; l_rm[k] = $urandom; l_rs[k] = rand_rs(); l_f[k] = 4'($urandom);
        end
        while (recv < 4 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc < 5);
            in_valid = sent < 4;
            if (sent < 4) drive(l_ins[sent], l_rn[sent], l_rm[sent], l_rs[sent], l_f[sent]);
            #1;
            if (hold) begin
                total++;
                if (out_valid !== 1'b1 || out_operand0 !== h_op0 || out_operand1 !== h_op1) begin
                    bad++; $display("FAIL bp_stable got=v%b %h/%h exp=v1 %h/%h", out_valid, out_operand0, out_operand1, h_op0, h_op1);
                end
            end
            if (stall_if) stalled = 1'b1;
            if (in_valid && in_ready) begin q.push_back(model(instruction, rd_data0, rd_data1, rd_data2, flags_nzcv)); sent++; end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL bp_extra got=%h exp=none", out_operand0); end
                else begin
                    e = q.pop_front();
                    if (out_operand0 !== e.op0 || (e.chk_op1 && out_operand1 !== e.op1) || out_nop !== e.nop) begin
                        bad++; $display("FAIL bp_order got=%h/%h exp=%h/%h", out_operand0, out_operand1, e.op0, e.op1);
                    end
                end
                recv++;
            end
            hold = out_valid && !out_ready;
            h_op0 = out_operand0;
            h_op1 = out_operand1;
            cyc++;
        end
        in_valid = 1'b0;
        total++; if (recv != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", recv); end
        total++; if (stalled !== 1'b1) begin bad++; $display("FAIL bp_stall_if got=0 exp=1"); end
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        exp_t q[$]; exp_t e;
        int sent = 0, cyc = 0, errs = 0;
        while ((sent < 400 || q.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            out_ready = $urandom_range(9) < 7;
            in_valid = sent < 400 && $urandom_range(3) != 0;
            drive_rand();
            #1;
            if (in_valid && in_ready) begin q.push_back(model(instruction, rd_data0, rd_data1, rd_data2, flags_nzcv)); sent++; end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rnd_extra got=%h exp=none", out_operand0); end
                else begin
                    e = q.pop_front();
                    if (out_operand0 !== e.op0 || (e.chk_op1 && out_operand1 !== e.op1) || (e.chk_carry && out_shift_carry !== e.carry) ||
                        {out_opcode, out_rd, out_update_flags, out_nop, out_undef} !== {e.opcode, e.rd, e.uf, e.nop, e.und}) begin
                        bad++;
                        if (errs++ < 10) $display("FAIL rnd got=%h/%b u%b n%b f%b exp=%h/%b u%b n%b f%b", out_operand1, out_shift_carry,
                                                  out_undef, out_nop, out_update_flags, e.op1, e.carry, e.und, e.nop, e.uf);
                    end
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        total++; if (sent != 400 || q.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d/%0d exp=400/0", sent, q.size()); end
    endtask

    task automatic test_reset_midstall();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive_rand();
        for (int i = 0; i < 6; i++) begin @(negedge clk); drive_rand(); end
        #1;
        total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL held got=v%b r%b exp=v1 r0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_operand0 !== 32'd0) begin bad++; $display("FAIL rst_flush got=v%b %h exp=v0 0", out_valid, out_operand0); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ghost got=%b exp=0", out_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        test_reset();
        test_rd_addr();
        test_rotate_imm();
        test_lsr32();
        test_reg_asr();
        test_cond();
        test_rrx();
        test_edges();
        test_backpressure();
        test_random();
        test_reset_midstall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arm_dp_decode_stage.md
Name: arm_dp_decode_stage

Overview:
- Registered decode stage for ARM data-processing instructions. Sits between fetch and ALU.
- Drives register-file read addresses, builds operand0 (Rn) and the full barrel-shifter operand1 with shifter carry-out, and evaluates the condition code against the current NZCV flags.
- Successor to the single-register operand decoder. Adds a valid/ready handshake, a configurable output pipeline depth, correct rotate-immediate, register-shift edge cases, and NOP/undefined marking.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported; any other value triggers an elaboration error.
- REG_AW, 4, register address width.
- OUT_STAGES, 1, number of output register slices (1 or 2). Each slice has its own valid/ready.

Ports:
- clk in 1: clock
- rst_n in 1: asynchronous active-low reset
- in_valid in 1: instruction valid from fetch
- in_ready out 1: stage can accept
- instruction in 32: instruction word
- flags_nzcv in 4: current N,Z,C,V from execute
- rd_addr0 out REG_AW: Rn = instruction[19:16] (combinational)
- rd_addr1 out REG_AW: Rm = instruction[3:0] (combinational)
- rd_addr2 out REG_AW: Rs = instruction[11:8] (combinational)
- rd_data0/1/2 in DATA_W: register file read data, same cycle
- out_valid out 1: decoded bundle valid
- out_ready in 1: ALU accepts
- out_operand0 out DATA_W: Rn value
- out_operand1 out DATA_W: shifter operand
- out_shift_carry out 1: shifter carry-out
- out_opcode out 4: instruction[24:21]
- out_rd out REG_AW: instruction[15:12]
- out_update_flags out 1: S bit AND NOT out_nop
- out_nop out 1: condition failed, or undefined
- out_undef out 1: not a decodable data-processing instruction
- stall_if out 1: in_valid AND NOT in_ready

Behaviour:
- Reset (asynchronous, rst_n low): all out_* registers = 0, all slice valids = 0. in_ready = 1 once reset is released.
- Accept when in_valid AND in_ready. rd_data and flags_nzcv are sampled on the accept edge.
- Latency: OUT_STAGES cycles from accept to out_valid when the pipeline is not stalled.
- Each slice loads when it is empty or its downstream slice is ready. A slice holds its contents stable while valid AND NOT ready.
- in_ready = NOT slice0_valid OR slice0_advances. Full throughput is 1 instruction per cycle.
- Condition codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE evaluated per ARM rules. AL (1110) always passes. Code 1111 forces out_nop = 1.
- Decoded class is instruction[27:26] == 00. Everything else sets out_undef = 1 and out_nop = 1.
- Also undefined: instruction[25] = 0 with instruction[7] = 1 and instruction[4] = 1 (multiply/extra load-store space).
- Also undefined: opcode 1000..1011 with S = 0.
- Immediate form (bit25 = 1): operand1 = imm8 rotated right by 2 × instruction[11:8]. Carry = operand1[31] if the rotate amount is nonzero, else C.
- Shift by immediate (bit4 = 0); type = [6:5], amount = [11:7]:
  - LSL #0: operand1 = Rm, carry = C.
  - LSR #0 encodes #32: result 0, carry = Rm[31].
  - ASR #0 encodes #32: result = 32 copies of Rm[31], carry = Rm[31].
  - Otherwise carry = last bit shifted out.
- Shift by register (bit4 = 1); amount = rd_data2[7:0]:
  - Amount 0: operand1 = Rm, carry = C.
  - LSL 32: result 0, carry = Rm[0]. LSL > 32: result 0, carry 0.
  - LSR 32: result 0, carry = Rm[31]. LSR > 32: result 0, carry 0.
  - ASR >= 32: result = sign fill, carry = Rm[31].
  - ROR: rotate by amount[4:0]. If amount[4:0] = 0 and amount != 0: carry = Rm[31].
- Immediate ROR (type 11, bit4 = 0) handling depends on ROR_RRX_EN.
- out_nop bundles still pass through the handshake; they are not dropped.
- Reset asserted mid-stall discards every in-flight bundle.

Optional Feature:
- ROR_RRX_EN defined:
  - ROR #n (n = 1..31) rotates, carry = result[31].
  - ROR #0 = RRX: result = {C, Rm[31:1]}, carry = Rm[0].
- ROR_RRX_EN undefined:
  - Immediate ROR/RRX and register ROR set out_undef = 1 and out_nop = 1.
  - out_operand1 = 0.

Test Plan:
- Rotate immediate: 0xE3A004FF (MOV r0, #0xFF ror 8), flags 0 → operand1 0xFF000000, carry 1, nop 0, after OUT_STAGES cycles.
- LSR #32 encoding: instr 0xE1A00021, Rm = 0x80000001 → operand1 0, carry 1.
- Register ASR: 0xE1A00251, Rm = 0x80000000, Rs = 40 → operand1 0xFFFFFFFF, carry 1.
- Condition fail: EQ instr 0x03A00001 with Z = 0 → out_valid 1, out_nop 1, out_update_flags 0. Same instr with Z = 1 → nop 0.
- Backpressure: stream 4 instrs, out_ready low for 3 cycles → stall_if high, outputs stable, no loss or duplication, order preserved.
- Reset mid-stall: rst_n low with 2 bundles held → out_valid 0 immediately, in_ready 1 after release. RRX case (macro on): 0xE1A00060, C = 1, Rm = 2 → 0x80000001, carry 0.
